// File: rtl/writeback_pkg.sv
// writeback_pkg: shared bundles for the write-back stage and its late-result FIFO
package writeback_pkg;
  localparam int XLEN = 32;
  localparam int RW = 5;
  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } writeback_pipe_in_type;
  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } writeback_late_in_type;
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] waddr;
  } writeback_issue_in_type;
  typedef struct packed {
    logic [RW-1:0] raddr1;
    logic [RW-1:0] raddr2;
    logic [RW-1:0] waddr;
  } writeback_check_in_type;
  typedef struct packed {
    logic            stall;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
  } writeback_check_out_type;
  typedef struct packed {
    logic            wren;
    logic [RW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } register_write_in_type;
  typedef struct packed {
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
  } register_out_type;
  typedef struct packed {
    logic [RW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } writeback_entry_type;
endpackage

// File: rtl/writeback_fifo.sv
// writeback_fifo: small circular buffer holding late results until the write port is free
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  writeback_entry_type din,
  output logic                full,
  output logic                empty,
  output writeback_entry_type head
);
  localparam int PW = $clog2(DEPTH);
  writeback_entry_type mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges pipe and late results onto the single register-file write port,
// tracks pending late destinations and forwards the registered write to decode operands
module writeback_unit
  import writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_waddr,
  input  logic [31:0] late_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_waddr,
  input  logic [4:0]  chk_raddr1,
  input  logic [4:0]  chk_raddr2,
  input  logic [4:0]  chk_waddr,
  output logic        stall,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] fwd_rdata1,
  output logic [31:0] fwd_rdata2,
  output logic        wb_wren,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata
);
  writeback_pipe_in_type   pipe;
  writeback_late_in_type   late;
  writeback_issue_in_type  issue;
  writeback_check_in_type  chk;
  writeback_check_out_type chk_out;
  register_out_type        rf;
  register_write_in_type   wb;
  writeback_entry_type     head;
  logic        full, empty, pipe_take, push, pop;
  logic [31:0] busy, set_mask, clr_mask;
  assign pipe  = '{pipe_valid, pipe_waddr, pipe_wdata};
  assign late  = '{late_valid, late_waddr, late_wdata};
  assign issue = '{issue_valid, issue_waddr};
  assign chk   = '{chk_raddr1, chk_raddr2, chk_waddr};
  assign rf    = '{rf_rdata1, rf_rdata2};
  // x0 pipe writes are dropped so they never steal the port from the FIFO
  assign pipe_take  = pipe.valid && pipe.waddr != '0;
  assign pop        = !pipe_take && !empty;
  assign push       = late.valid && !full;
  assign late_ready = !full;
  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ('{late.waddr, late.wdata}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) wb <= '0;
    else if (pipe_take) wb <= '{1'b1, pipe.waddr, pipe.wdata};
    else if (pop) wb <= '{head.waddr != '0, head.waddr, head.wdata};
    else wb.wren <= 1'b0;
  always_comb begin
    set_mask = (issue.valid && issue.waddr != '0) ? 32'(1) << issue.waddr : '0;
    clr_mask = pop ? 32'(1) << head.waddr : '0;
  end
  // set is applied after clear so a same-cycle reissue keeps the register busy
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= ((busy & ~clr_mask) | set_mask) & ~32'(1);
  always_comb begin
    chk_out.stall  = busy[chk.raddr1] | busy[chk.raddr2] | busy[chk.waddr];
    chk_out.rdata1 = (wb.wren && wb.waddr == chk.raddr1 && chk.raddr1 != '0) ? wb.wdata : rf.rdata1;
    chk_out.rdata2 = (wb.wren && wb.waddr == chk.raddr2 && chk.raddr2 != '0) ? wb.wdata : rf.rdata2;
  end
  assign stall      = chk_out.stall;
  assign fwd_rdata1 = chk_out.rdata1;
  assign fwd_rdata2 = chk_out.rdata2;
  assign wb_wren    = wb.wren;
  assign wb_waddr   = wb.waddr;
  assign wb_wdata   = wb.wdata;
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back stage that feeds the integer register file's single write port.
- Merges in-order single-cycle results (pipe) with out-of-order multi-cycle results (late: load/divide) through a small FIFO.
- Keeps a 32-bit busy scoreboard so decode stalls on pending late destinations.
- Forwards the registered write-port contents onto register-file read data.

Parameters:
- DEPTH, 2, late-result FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pipe_valid  in  1  single-cycle result valid; never stalled
- pipe_waddr  in  5  destination register
- pipe_wdata  in  32  result data
- late_valid  in  1  multi-cycle result valid
- late_ready  out  1  FIFO can accept a late result
- late_waddr  in  5  destination register
- late_wdata  in  32  result data
- issue_valid  in  1  a late operation is issued this cycle
- issue_waddr  in  5  its destination register
- chk_raddr1  in  5  decode source 1
- chk_raddr2  in  5  decode source 2
- chk_waddr  in  5  decode destination
- stall  out  1  decode hazard
- rf_rdata1  in  32  register-file read data 1 (addressed by chk_raddr1)
- rf_rdata2  in  32  register-file read data 2 (addressed by chk_raddr2)
- fwd_rdata1  out  32  forwarded operand 1
- fwd_rdata2  out  32  forwarded operand 2
- wb_wren  out  1  register-file write enable
- wb_waddr  out  5  register-file write address
- wb_wdata  out  32  register-file write data

Behaviour:
- Reset (async, rst=1):
  - wb_wren=0, wb_waddr=0, wb_wdata=0.
  - FIFO empty; busy=0.
  - late_ready=1 once rst deasserts.
  - Reset mid-operation discards all FIFO contents and pending busy bits.
- Arbitration (each cycle, result registered into wb_* at the next edge; latency 1):
  - pipe_valid=1 and pipe_waddr!=0: load pipe result; FIFO not popped.
  - Else, FIFO non-empty: pop head into wb_*.
  - Else: wb_wren<=0; wb_waddr/wb_wdata hold their previous values.
  - Pipe writes to x0 are dropped and do not block the FIFO.
- FIFO:
  - late_ready = (count != DEPTH). Computed from count only; a pop in the same cycle does not free a slot.
  - Push when late_valid & late_ready. late_valid while late_ready=0 must be held by the producer (no loss).
  - Late results with late_waddr=0 are pushed and popped normally, but written back with wb_wren=0.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
  - Minimum late latency: late_valid to wb_wren = 2 cycles (push, then pop).
  - Starvation from continuous pipe writes is allowed; the pipe never stalls.
- Scoreboard busy[31:0]:
  - Set: issue_valid & issue_waddr!=0 sets busy[issue_waddr] at the edge.
  - Clear: busy[a] clears at the edge where a FIFO entry with address a is loaded into wb_*.
  - Same address set and cleared in one cycle: set wins.
  - busy[0] is always 0.
- stall (combinational) = busy[chk_raddr1] | busy[chk_raddr2] | busy[chk_waddr].
  - Decode guarantees no pipe write and no second issue to a busy register. A bench assertion flags either violation.
- Forwarding (combinational):
  - fwd_rdata1 = wb_wdata when wb_wren & wb_waddr==chk_raddr1 & chk_raddr1!=0; otherwise rf_rdata1.
  - fwd_rdata2 follows the same rule with chk_raddr2 and rf_rdata2.
- Widths: FIFO count is clog2(DEPTH)+1 bits; pointers are clog2(DEPTH) bits.

Decomposition:
- Shared package wires:
  - writeback_pipe_in_type (valid, waddr, wdata)
  - writeback_late_in_type (valid, waddr, wdata)
  - writeback_issue_in_type
  - writeback_check_in_type / writeback_check_out_type
- wb_* bundle reuses register_write_in_type; rf_rdata* reuses register_out_type.
- Sub-module writeback_fifo (DEPTH entries of {waddr, wdata}):
  - inputs: push, pop
  - outputs: full, empty, head
- Arbiter, scoreboard and forwarding stay in writeback_unit.

Test Plan:
- Pipe-only: pipe_valid, waddr=5, wdata=0x11 -> next cycle wb_wren=1, wb_waddr=5, wb_wdata=0x11. Same cycle, chk_raddr1=5 -> fwd_rdata1=0x11.
- Late path:
  - issue_waddr=7 -> stall=1 for chk_raddr2=7.
  - late_valid waddr=7, wdata=0xABCD with no pipe -> wb_wren=1 with 0xABCD exactly 2 cycles later.
  - busy[7] clears at that edge; stall drops.
- Contention:
  - Pipe writes every cycle for 4 cycles while 3 late results arrive.
  - late_ready goes low after 2 pushes; third result is held.
  - Late results write back in arrival order once pipe idles.
  - No result lost or duplicated.
- x0 handling:
  - pipe_waddr=0 with FIFO holding waddr=3 -> FIFO pops; wb_waddr=3.
  - issue_waddr=0 -> busy stays 0; chk_raddr1=0 never forwards.
- Set/clear race: issue_waddr=9 in the cycle a FIFO entry for 9 is popped -> busy[9]=1 afterwards.
- Async reset mid-run with 2 FIFO entries and busy bits set:
  - Assert rst between edges -> wb_wren=0 immediately, busy=0, FIFO empty.
  - After release, late_ready=1.
